// File: rtl/ser_feeder_pkg.sv
// Shared types and operation codes for the serial feeder and its
// downstream shift register.
package ser_feeder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [1:0] OPR_SHIFT = 2'd0;
   localparam logic [1:0] OPR_HOLD  = 2'd1;
   localparam logic [1:0] OPR_CLEAR = 2'd2;

endpackage

// File: rtl/ser_feeder_shreg.sv
// N-bit serial-in shift register driven by ser_feeder (clear / shift / hold).
// Its reset input is active-low and synchronous.
module ser_feeder_shreg
   import ser_feeder_pkg::*;
#(
   parameter int N = 8
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   opr,
   input  logic         l,
   output logic [N-1:0] q
);

   always_ff @(posedge clk) begin
      if (!rst) begin
         q <= '0;
      end else begin
         case (opr)
            OPR_SHIFT: q <= {q[N-2:0], l};
            OPR_CLEAR: q <= '0;
            default:   q <= q;
         endcase
      end
   end

endmodule

// File: rtl/ser_feeder.sv
// Serialises a handshaked parallel word into a shift register: clear, N shifts, done.
// Build option SER_FEEDER_LSB_FIRST_EN sends bits LSB-first instead of MSB-first.
module ser_feeder
   import ser_feeder_pkg::*;
#(
   parameter int N = 8
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] din,
   input  logic         din_valid,
   output logic         din_ready,
   output logic         l,
   output logic [1:0]   opr,
   output logic         busy,
   output logic         done
);

   localparam int            CW   = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [N-1:0]  sh, sh_nxt;
   logic [CW-1:0] bidx;

`ifdef SER_FEEDER_LSB_FIRST_EN
   assign bidx = cnt;
`else
   assign bidx = LAST - cnt;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         sh    <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         sh    <= sh_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      sh_nxt    = sh;
      din_ready = 1'b0;
      opr       = OPR_HOLD;
      l         = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;

      case (state)
         IDLE: begin
            din_ready = 1'b1;
            if (din_valid) begin
               sh_nxt    = din;
               cnt_nxt   = '0;
               state_nxt = CLEAR;
            end
         end
         CLEAR: begin
            opr       = OPR_CLEAR;
            busy      = 1'b1;
            state_nxt = SHIFT;
         end
         SHIFT: begin
            opr  = OPR_SHIFT;
            busy = 1'b1;
            l    = sh[bidx];
            // counter parks on the last index rather than wrapping
            if (cnt == LAST) begin
               state_nxt = DONE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // reset overrides the state decode so nothing leaks out during reset
      if (rst) begin
         din_ready = 1'b0;
         opr       = OPR_HOLD;
         l         = 1'b0;
         busy      = 1'b0;
         done      = 1'b0;
      end
   end

endmodule

// File: tb/tb_ser_feeder.sv
// Scoreboard bench: ser_feeder driving ser_feeder_shreg, checking q, bit order and timing.
module tb_ser_feeder;
   import ser_feeder_pkg::*;

   localparam int N = 8;

`ifdef SER_FEEDER_LSB_FIRST_EN
   localparam logic [7:0] R01 = 8'h80;
`else
   localparam logic [7:0] R01 = 8'h01;
`endif

   typedef struct {
      logic [7:0] q;
      logic [7:0] lseq;
      int         dcyc;
   } exp_t;

   logic         clk;
   logic         rst;
   logic [N-1:0] din;
   logic         din_valid;
   logic         din_ready;
   logic         l;
   logic [1:0]   opr;
   logic         busy;
   logic         done;
   logic [N-1:0] q;

   int   cyc = 0;
   int   ntotal = 0;
   int   npass = 0;
   exp_t sbq[$];

   ser_feeder #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .l         (l),
      .opr       (opr),
      .busy      (busy),
      .done      (done)
   );

   ser_feeder_shreg #(.N(N)) sreg (
      .clk (clk),
      .rst (~rst),
      .opr (opr),
      .l   (l),
      .q   (q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      ntotal++;
      if (act === req) npass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // {din_ready, busy, done, l, opr}
   function automatic logic [5:0] outs();
      return {din_ready, busy, done, l, opr};
   endfunction

   task automatic send(input logic [7:0] w, input logic [7:0] eq, input logic [7:0] el,
                       output int c);
      din       = w;
      din_valid = 1'b1;
      c         = -1;
      for (int i = 0; i < 60; i++) begin
         if (din_ready) begin
            c = cyc;
            sbq.push_back('{q: eq, lseq: el, dcyc: cyc + N + 2});
            break;
         end
         step();
      end
      if (c < 0) begin
         ntotal++;
         $display("FAIL accept_timeout: word %0h never accepted", w);
      end
      step();
   endtask

   // monitor: assembles l bits per frame and scores each done pulse
   int         mnsh = 0;
   logic       mclr = 1'b0;
   logic [7:0] mlb  = '0;
   exp_t       cur;

   always @(negedge clk) begin
      if (rst) begin
         mnsh = 0;
         mclr = 1'b0;
         mlb  = '0;
      end else begin
         if (opr == OPR_CLEAR) begin
            mnsh = 0;
            mclr = 1'b1;
            mlb  = '0;
         end else if (opr == OPR_SHIFT) begin
            mnsh++;
            mlb = {mlb[6:0], l};
         end
         if (done) begin
            if (sbq.size() == 0) begin
               ntotal++;
               $display("FAIL unexpected_done: done pulse with no frame pending (cycle %0d)", cyc);
            end else begin
               cur = sbq.pop_front();
               chk("frame_q", 32'(q), 32'(cur.q));
               chk("frame_lseq", 32'(mlb), 32'(cur.lseq));
               chk("frame_clear_shifts", {23'd0, mclr, 8'(mnsh)}, {23'd0, 1'b1, 8'd8});
               chk("frame_done_cycle", 32'(cyc), 32'(cur.dcyc));
               chk("frame_done_outs", 32'(outs()), 32'(6'b011001));
            end
            mclr = 1'b0;
            mnsh = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c1, c2;
      rst       = 1'b1;
      din       = '0;
      din_valid = 1'b0;
      repeat (3) step();
      chk("reset_forced_outs", 32'(outs()), 32'(6'b000001));
      rst = 1'b0;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk("idle_outs", 32'(outs()), 32'(6'b100001));
         step();
      end

      send(8'hA5, 8'hA5, 8'hA5, c1);
      din_valid = 1'b0;

      send(8'h3C, 8'h3C, 8'h3C, c1);
      send(8'hC3, 8'hC3, 8'hC3, c2);
      din_valid = 1'b0;
      chk("b2b_period", 32'(c2 - c1), 32'd11);

      send(8'h01, R01, R01, c1);
      repeat (3) step();
      din = 8'hFF;
      send(8'hFF, 8'hFF, 8'hFF, c2);
      din_valid = 1'b0;
      chk("pending_accept", 32'(c2 - c1), 32'd11);

      send(8'h5A, 8'h5A, 8'h5A, c1);
      din_valid = 1'b0;
      repeat (4) step();
      rst = 1'b1;
      void'(sbq.pop_back());
      #1;
      chk("midframe_rst_outs", 32'(outs()), 32'(6'b000001));
      step();
      chk("rst_held_outs", 32'(outs()), 32'(6'b000001));
      rst = 1'b0;
      #1;
      chk("after_rst_idle", 32'(outs()), 32'(6'b100001));

      send(8'h81, 8'h81, 8'h81, c1);
      din_valid = 1'b0;

      repeat (15) step();
      chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule

// File: doc/ser_feeder.md
# ser_feeder

Upstream control stage for the `N`-bit serial-in shift register. It accepts a parallel word through a valid/ready handshake. It then drives the register's serial input `l` and its 2-bit operation code `opr` so that the word is assembled in the register's parallel output `q`. One frame is: clear the register, shift `N` bits in, hold. Completion is flagged with a one-cycle `done` pulse.

## Interface
- `N`, 8, word width; must match the downstream shift register width; N ≥ 2.
- `clk` input 1 — sole clock; all state updates on rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `din` input N — parallel word to serialize.
- `din_valid` input 1 — `din` is valid this cycle.
- `din_ready` output 1 — block can accept a word this cycle.
- `l` output 1 — serial bit to the shift register's `l` input.
- `opr` output 2 — operation code to the shift register:
  - 0 = shift (register loads `{q[N-2:0], l}`)
  - 1 = hold
  - 2 = clear
  - 3 is never driven
- `busy` output 1 — a frame is in progress.
- `done` output 1 — one-cycle pulse; the downstream `q` holds the complete word.

## Operation
- FSM states: IDLE, CLEAR, SHIFT, DONE; Moore outputs decoded from registered state.
- IDLE:
  - Outputs: `din_ready`=1, `opr`=1, `l`=0, `busy`=0, `done`=0.
  - On `din_valid && din_ready`: latch `din` into internal shadow register `sh`, load bit counter `cnt`=0, go to CLEAR.
- CLEAR (exactly 1 cycle):
  - Outputs: `opr`=2, `l`=0, `busy`=1, `din_ready`=0.
  - Go to SHIFT.
- SHIFT (exactly N cycles):
  - Outputs: `opr`=0, `busy`=1, `din_ready`=0.
  - `l` = `sh[N-1-cnt]` (MSB-first), so after N shifts the downstream `q` equals the latched word bit-for-bit.
  - `cnt` increments each cycle. When `cnt`==N-1, go to DONE.
- DONE (exactly 1 cycle):
  - Outputs: `opr`=1, `done`=1, `busy`=1, `l`=0, `din_ready`=0.
  - Go to IDLE.
- `cnt` width is `$clog2(N)`. The terminal compare is against N-1; the counter never wraps past N-1.
- `din` and `din_valid` are ignored outside IDLE. A word presented while busy is not consumed and stays pending until IDLE.
- `sh` is held stable for the whole frame. Changes on `din` mid-frame have no effect.

## Timing
- Reset (`rst`=1 at a rising edge):
  - Next state is IDLE, `cnt`=0, `sh`=0.
  - While `rst` is high, all outputs are forced: `din_ready`=0, `opr`=1, `l`=0, `busy`=0, `done`=0.
  - `din_ready` rises in the first cycle after `rst` deasserts.
- Reset mid-frame: the frame is aborted; IDLE on the next edge; no `done` pulse. The downstream register keeps its partial contents until the next CLEAR.
- Frame timeline, with the handshake accepted at edge k:
  - CLEAR during cycle k+1.
  - Shifts during cycles k+2 … k+N+1.
  - DONE during cycle k+N+2.
  - IDLE (`din_ready`=1) at cycle k+N+3.
- Minimum frame period is N+3 cycles. `done` coincides with the first cycle in which the downstream `q` equals the word.
- `din_valid` held high continuously yields back-to-back frames separated by exactly one IDLE cycle.

## Configuration
- `SER_FEEDER_LSB_FIRST_EN`:
  - Defined: `l` = `sh[cnt]` in SHIFT, so the downstream `q` ends up bit-reversed relative to `din`.
  - Undefined (default): MSB-first as specified above.
- FSM timing, handshake and all other outputs are identical in both builds.

## Structure
- Shared package `ser_feeder_pkg`:
  - FSM state enum: IDLE, CLEAR, SHIFT, DONE.
  - `opr` code constants: `OPR_SHIFT`=0, `OPR_HOLD`=1, `OPR_CLEAR`=2.
  - The downstream shift register uses the same `opr` constants.
- No sub-module in the feeder itself; FSM, counter and shadow register live in one module.
- The bench instantiates `ser_feeder` driving the existing shift register (rst of the register tied to `~rst`) to check `q` end-to-end.

## Test plan
All scenarios use N=8.
- Reset release, `din_valid`=0 for 5 cycles → `din_ready`=1, `opr`=1, `busy`=0, `done`=0 throughout.
- Accept 8'hA5 (MSB-first build):
  - `opr` sequence is 2, then 0×8, then 1.
  - `l` during the shifts is 1,0,1,0,0,1,0,1.
  - `done` pulses at cycle k+10 with downstream `q`=8'hA5.
- `din_valid` held high with 8'h3C then 8'hC3 → two frames 11 cycles apart; `q`=8'h3C then 8'hC3; exactly one IDLE cycle between them.
- `din` changed to 8'hFF mid-SHIFT of an 8'h01 frame → `q`=8'h01 at `done`; 8'hFF is accepted only on return to IDLE.
- `rst` pulsed for 1 cycle at the 4th shift → no `done`; IDLE, `opr`=1 next cycle; a following 8'h81 frame yields `q`=8'h81.
- Build with `SER_FEEDER_LSB_FIRST_EN`, accept 8'h01 → `l` sequence 1,0,0,0,0,0,0,0; `q`=8'h80 at `done`.
